pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Drives the `halt` inputs of the fetch and operand-fetch stages, and a bubble-insert into execute.
- Resolves three hazard sources, in priority order: taken-branch flush, data-memory wait, load-use.
- Small registered FSM plus a cycle counter. Hazard outputs are Mealy, so a hazard halts the pipeline in the same cycle it is detected.

Parameters:
- XLEN, 32, datapath width; width of `id_instr`.
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- FLUSH_CYCLES, 2, cycles flush is held after a taken branch/jump (1..7).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- id_instr  in  XLEN  instruction currently in the operand-fetch stage output.
- ex_rd  in  5  destination register of the instruction in execute.
- ex_is_load  in  1  execute instruction is a load.
- ex_branch_taken  in  1  execute resolved a taken branch, JAL or JALR.
- dmem_busy  in  1  data memory not ready this cycle.
- halt_if  out  1  hold fetch/PC.
- halt_of  out  1  hold the operand-fetch register.
- bubble_ex  out  1  execute latches a NOP instead of the OF output.
- flush_of  out  1  invalidate the OF contents (wrong-path instruction).
- ctrl_state  out  2  current FSM state, for debug.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset effects:
  - state=RUN, counter=0.
  - While rst=1: halt_if=1, halt_of=1, bubble_ex=1, flush_of=0.
  - rst asserted mid-stall or mid-flush aborts the sequence. First cycle after rst falls is RUN with no hazard carried over.
- Encodings, in ctrl_pkg: RUN=0, LU_STALL=1, FLUSH=2, MEM_WAIT=3.
- Source decode from id_instr:
  - opcode=[6:0], rs1=[19:15], rs2=[24:20].
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
- Load-use hit: ex_is_load=1 AND ex_rd!=0 AND ex_rd equals a used source.
- Priority each cycle: rst > ex_branch_taken > dmem_busy > load-use > none.
- RUN:
  - branch_taken: flush_of=1, bubble_ex=1, halt none. Load counter=FLUSH_CYCLES-1. Go to FLUSH, or stay in RUN if FLUSH_CYCLES=1.
  - dmem_busy: halt_if=halt_of=1. Save ret_state=RUN. Go to MEM_WAIT.
  - load-use: halt_if=halt_of=1, bubble_ex=1. Load counter=LU_STALL_CYCLES-1. Go to LU_STALL, or stay in RUN if the count is 1.
  - otherwise: all outputs 0.
- LU_STALL:
  - halt_if=halt_of=bubble_ex=1.
  - Counter decrements; leave to RUN when counter=0.
  - branch_taken preempts: go to FLUSH.
  - dmem_busy: save ret_state=LU_STALL and freeze the counter.
- FLUSH:
  - flush_of=bubble_ex=1.
  - Counter decrements; go to RUN at 0.
  - A new branch_taken reloads the counter.
  - dmem_busy: save ret_state=FLUSH and freeze the counter.
- MEM_WAIT:
  - halt_if=halt_of=1, bubble_ex=0 (execute is stalled by memory, not bubbled).
  - When dmem_busy=0, return to ret_state with the counter intact.
  - branch_taken while in MEM_WAIT is ignored. Execute is frozen, so it cannot legally assert it.
- Counter is 3 bits and never wraps. A decrement at 0 is illegal and asserted in simulation.
- halt_of=1 while flush_of=1 never occurs.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_lu_cycles[31:0], perf_flush_cycles[31:0], perf_mem_cycles[31:0].
  - Each counts the cycles spent with the corresponding hazard active, including the entry cycle.
  - Saturates at all-ones. Cleared by rst.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- ctrl_pkg holds:
  - ctrl_state_t enum.
  - RV32I opcode localparams: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - NOP constant 32'h00000013.
- One sub-module, `src_use_decode` (combinational). Maps id_instr to uses_rs1, uses_rs2, rs1, rs2.

Test Plan:
- Reset: hold rst 3 cycles with all inputs active → halt_if=halt_of=bubble_ex=1, flush_of=0. Cycle after release: ctrl_state=0, all outputs 0.
- Load-use: ex_is_load=1, ex_rd=5, id_instr=add x1,x5,x2 (0x002280B3) → one cycle of halt_if=halt_of=bubble_ex=1, then RUN. Same stimulus with ex_rd=0 → no stall.
- Branch flush: ex_branch_taken pulse 1 cycle, FLUSH_CYCLES=2 → flush_of=bubble_ex=1 for exactly 2 cycles, halt_if=0 throughout.
- Simultaneous: load-use hit and ex_branch_taken in the same cycle → FLUSH taken, no LU_STALL cycle.
- Memory wait mid-flush: dmem_busy high 3 cycles starting in the 2nd FLUSH cycle → 3 cycles MEM_WAIT (halts=1, flush_of=0), then 1 remaining FLUSH cycle, then RUN.
- Reset mid-stall: LU_STALL_CYCLES=3, assert rst in stall cycle 2 → after release, RUN with no residual bubble. With HAZARD_PERF_CNT_EN, all perf counters read 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the pipeline hazard controller.
//   ctrl_state_t : sequencer state encoding (also driven out on ctrl_state)
//   OP..AUIPC    : RV32I major opcodes used by the source-register decoder
//   NOP          : canonical RV32I no-op (addi x0, x0, 0)
// ---------------------------------------------------------------------------
package ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } ctrl_state_t;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/src_use_decode.sv
// ---------------------------------------------------------------------------
// src_use_decode
// Combinational decode of which source registers an instruction reads.
// Ports:
//   id_instr  in  XLEN  instruction leaving operand fetch
//   uses_rs1  out 1     instruction reads rs1
//   uses_rs2  out 1     instruction reads rs2
//   rs1, rs2  out 5     source register fields
// ---------------------------------------------------------------------------
module src_use_decode
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] id_instr,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2
);

  logic [6:0] opcode;
  // Fields not involved in hazard detection; named so lint treats them as
  // intentionally unused.
  logic       unused_fields;

  assign opcode        = id_instr[6:0];
  assign rs1           = id_instr[19:15];
  assign rs2           = id_instr[24:20];
  assign unused_fields = ^{id_instr[XLEN-1:25], id_instr[14:7]};

  // JAL, LUI and AUIPC carry immediates in the register field positions,
  // so they must not be matched against the load destination.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    unique case (opcode)
      OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_IMM: uses_rs1 = 1'b1;
      LOAD:   uses_rs1 = 1'b1;
      JALR:   uses_rs1 = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage RV32I pipeline. Hazard outputs are
// Mealy: a hazard halts or flushes the pipeline in the cycle it appears.
// Priority: rst > taken branch > data-memory wait > load-use.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   id_instr          instruction leaving operand fetch
//   ex_rd, ex_is_load destination / load flag of the execute instruction
//   ex_branch_taken   execute resolved a taken branch/jump
//   dmem_busy         data memory not ready this cycle
//   halt_if, halt_of  hold fetch and operand-fetch registers
//   bubble_ex         execute latches a NOP
//   flush_of          invalidate operand-fetch contents
//   ctrl_state        current sequencer state (debug)
// Optional macro HAZARD_PERF_CNT_EN adds saturating 32-bit cycle counters
//   perf_lu_cycles, perf_flush_cycles, perf_mem_cycles.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import ctrl_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int LU_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] id_instr,
  input  logic [4:0]      ex_rd,
  input  logic            ex_is_load,
  input  logic            ex_branch_taken,
  input  logic            dmem_busy,
  output logic            halt_if,
  output logic            halt_of,
  output logic            bubble_ex,
  output logic            flush_of,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]     perf_lu_cycles,
  output logic [31:0]     perf_flush_cycles,
  output logic [31:0]     perf_mem_cycles,
`endif
  output logic [1:0]      ctrl_state
);

  localparam logic [2:0] LU_LOAD    = 3'(LU_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  ctrl_state_t state_q, state_d;
  ctrl_state_t ret_q, ret_d;
  ctrl_state_t eff_state;
  logic [2:0]  cnt_q, cnt_d;
  logic        cnt_dec;
  logic        branch_ok;
  logic        lu_hit;
  logic        uses_rs1, uses_rs2;
  logic [4:0]  rs1, rs2;
  logic        lu_act, flush_act, mem_act;

  src_use_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .id_instr (id_instr),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .rs1      (rs1),
    .rs2      (rs2)
  );

  assign lu_hit = ex_is_load && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

  // Execute is frozen during a memory wait, so a branch indication there is
  // not genuine and is discarded.
  assign branch_ok = ex_branch_taken && (state_q != MEM_WAIT);

  // Once memory releases, the interrupted sequence resumes in that very
  // cycle, so the saved state governs this cycle's outputs.
  assign eff_state = (state_q == MEM_WAIT && !dmem_busy) ? ret_q : state_q;

  // Next-state and Mealy output logic. The counter holds the number of
  // hazard cycles still owed after the current one.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    cnt_dec   = 1'b0;
    halt_if   = 1'b0;
    halt_of   = 1'b0;
    bubble_ex = 1'b0;
    flush_of  = 1'b0;
    lu_act    = 1'b0;
    flush_act = 1'b0;
    mem_act   = 1'b0;

    if (rst) begin
      halt_if   = 1'b1;
      halt_of   = 1'b1;
      bubble_ex = 1'b1;
      state_d   = RUN;
      ret_d     = RUN;
      cnt_d     = 3'd0;
    end else if (eff_state == MEM_WAIT) begin
      halt_if = 1'b1;
      halt_of = 1'b1;
      mem_act = 1'b1;
    end else if (branch_ok) begin
      flush_of  = 1'b1;
      bubble_ex = 1'b1;
      flush_act = 1'b1;
      cnt_d     = FLUSH_LOAD;
      state_d   = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
    end else if (dmem_busy) begin
      // Counter is left untouched so the interrupted sequence can resume.
      halt_if = 1'b1;
      halt_of = 1'b1;
      mem_act = 1'b1;
      ret_d   = eff_state;
      state_d = MEM_WAIT;
    end else begin
      unique case (eff_state)
        RUN: begin
          state_d = RUN;
          if (lu_hit) begin
            halt_if   = 1'b1;
            halt_of   = 1'b1;
            bubble_ex = 1'b1;
            lu_act    = 1'b1;
            cnt_d     = LU_LOAD;
            state_d   = (LU_STALL_CYCLES == 1) ? RUN : LU_STALL;
          end
        end
        LU_STALL: begin
          halt_if   = 1'b1;
          halt_of   = 1'b1;
          bubble_ex = 1'b1;
          lu_act    = 1'b1;
          cnt_dec   = 1'b1;
          cnt_d     = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
          state_d   = (cnt_q <= 3'd1) ? RUN : LU_STALL;
        end
        FLUSH: begin
          flush_of  = 1'b1;
          bubble_ex = 1'b1;
          flush_act = 1'b1;
          cnt_dec   = 1'b1;
          cnt_d     = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
          state_d   = (cnt_q <= 3'd1) ? RUN : FLUSH;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Sequencer registers. The embedded checks flag a counter underflow and
  // the forbidden combination of holding and flushing operand fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      assert (!(cnt_dec && cnt_q == 3'd0));
      assert (!(halt_of && flush_of));
    end
  end

  assign ctrl_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_lu_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [31:0] perf_mem_q, perf_mem_d;

  // Saturating occupancy counters, one per hazard class.
  always_comb begin
    perf_lu_d    = perf_lu_q;
    perf_flush_d = perf_flush_q;
    perf_mem_d   = perf_mem_q;
    if (lu_act && perf_lu_q != 32'hFFFF_FFFF)
      perf_lu_d = perf_lu_q + 32'd1;
    if (flush_act && perf_flush_q != 32'hFFFF_FFFF)
      perf_flush_d = perf_flush_q + 32'd1;
    if (mem_act && perf_mem_q != 32'hFFFF_FFFF)
      perf_mem_d = perf_mem_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_q    <= 32'd0;
      perf_flush_q <= 32'd0;
      perf_mem_q   <= 32'd0;
    end else begin
      perf_lu_q    <= perf_lu_d;
      perf_flush_q <= perf_flush_d;
      perf_mem_q   <= perf_mem_d;
    end
  end

  assign perf_lu_cycles    = perf_lu_q;
  assign perf_flush_cycles = perf_flush_q;
  assign perf_mem_cycles   = perf_mem_q;
`else
  logic unused_act;
  assign unused_act = lu_act ^ flush_act ^ mem_act;
`endif

endmodule
